// File: rtl/inst_fetch_pkg.sv
// Shared CPU package: opcode constants, NOP encoding and fetch FSM encoding.
// Also imported by the control unit.
package inst_fetch_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } fetch_state_t;

  localparam logic [6:0]  OP_IMM   = 7'b0010011;
  localparam logic [6:0]  OP_REG   = 7'b0110011;
  localparam logic [6:0]  OP_LUI   = 7'b0110111;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/inst_fetch_imm_gen.sv
// Combinational immediate decoder: I-type for OP_IMM, U-type for OP_LUI,
// zero for every other opcode.
module imm_gen
  import inst_fetch_pkg::*;
(
  input  logic [31:0] i_ir,
  output logic [31:0] o_imm
);

  logic [6:0] w_opcode;

  assign w_opcode = i_ir[6:0];

  always_comb begin
    o_imm = '0;
    case (w_opcode)
      OP_IMM:  o_imm = sext12(i_ir[31:20]);
      OP_LUI:  o_imm = {i_ir[31:12], 12'b0};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: two-state request/ack handshake, IR latch, PC advance
// and field decode. Define IFETCH_WATCHDOG_EN to add a REQ-cycle watchdog.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IR_Write,
  input  logic        PC_Write,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic        ir_valid,
  output logic        busy,
  output logic        fetch_err
);

  // Low address bits are dropped so a misaligned override still yields a legal PC.
  localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_ir;
  logic [31:0]  r_pc;
  logic         r_adv_pending;
  logic         r_ir_valid;
  logic         w_ir_load;
  logic         w_fetch_start;
  logic         w_wd_expire;

  always_comb begin
    w_state_nxt   = r_state;
    w_ir_load     = 1'b0;
    w_fetch_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (IR_Write) begin
          w_state_nxt   = ST_REQ;
          w_fetch_start = 1'b1;
        end
      end
      ST_REQ: begin
        // A same-cycle ack wins over watchdog expiry.
        if (imem_ack) begin
          w_state_nxt = ST_IDLE;
          w_ir_load   = 1'b1;
        end else if (w_wd_expire) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_ir          <= NOP_INSN;
      r_pc          <= RESET_PC_W;
      r_adv_pending <= 1'b0;
      r_ir_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ir_valid <= w_ir_load;
      if (w_fetch_start) begin
        r_adv_pending <= PC_Write;
      end
      if (w_ir_load) begin
        r_ir <= imem_rdata;
        if (r_adv_pending) begin
          r_pc <= r_pc + 32'd4;
        end
      end
    end
  end

`ifdef IFETCH_WATCHDOG_EN
  localparam int unsigned WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_fetch_err;

  // Count holds the number of REQ cycles already spent, so expiry fires in cycle TIMEOUT_CYC.
  assign w_wd_expire = (r_state == ST_REQ) && !imem_ack &&
                       (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd_cnt    <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      if (r_state != ST_REQ) begin
        r_wd_cnt <= '0;
      end else if (!imem_ack) begin
        r_wd_cnt <= r_wd_cnt + WD_W'(1);
      end
      if (w_wd_expire) begin
        r_fetch_err <= 1'b1;
      end
    end
  end

  assign fetch_err = r_fetch_err;
`else
  assign w_wd_expire = 1'b0;
  assign fetch_err   = 1'b0;
`endif

  imm_gen u_imm_gen (
    .i_ir  (r_ir),
    .o_imm (imm)
  );

  assign imem_req  = (r_state == ST_REQ);
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign busy      = (r_state != ST_IDLE);
  assign ir_valid  = r_ir_valid;
  assign opcode    = r_ir[6:0];
  assign funct3    = r_ir[14:12];
  assign funct7    = r_ir[31:25];
  assign rs1       = r_ir[19:15];
  assign rs2       = r_ir[24:20];
  assign rd        = r_ir[11:7];

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: fetches push expectations, a negedge monitor
// pops and compares on every ir_valid pulse.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        IR_Write, PC_Write, imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req, ir_valid, busy, fetch_err;
  logic [31:0] imem_addr, pc, imm;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;

  logic        IR_Write2, PC_Write2, imem_ack2;
  logic [31:0] imem_rdata2;
  logic        imem_req2, ir_valid2, busy2, fetch_err2;
  logic [31:0] imem_addr2, pc2, imm2;
  logic [6:0]  opcode2, funct72;
  logic [2:0]  funct32;
  logic [4:0]  rs12, rs22, rd2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] imm;
    logic [31:0] pc;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk(clk), .rst(rst), .IR_Write(IR_Write), .PC_Write(PC_Write),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .pc(pc), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .ir_valid(ir_valid), .busy(busy), .fetch_err(fetch_err)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .IR_Write(IR_Write2), .PC_Write(PC_Write2),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2),
    .imem_rdata(imem_rdata2), .pc(pc2), .opcode(opcode2), .funct3(funct32),
    .funct7(funct72), .rs1(rs12), .rs2(rs22), .rd(rd2), .imm(imm2),
    .ir_valid(ir_valid2), .busy(busy2), .fetch_err(fetch_err2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ir_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_ir_valid", {31'b0, ir_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("opcode", {25'b0, opcode}, {25'b0, e.ir[6:0]});
        chk("funct3", {29'b0, funct3}, {29'b0, e.ir[14:12]});
        chk("funct7", {25'b0, funct7}, {25'b0, e.ir[31:25]});
        chk("rs1",    {27'b0, rs1},    {27'b0, e.ir[19:15]});
        chk("rs2",    {27'b0, rs2},    {27'b0, e.ir[24:20]});
        chk("rd",     {27'b0, rd},     {27'b0, e.ir[11:7]});
        chk("imm",    imm, e.imm);
        chk("pc",     pc,  e.pc);
      end
    end
  end

  // Caller is 1 time unit after a rising edge with the DUT idle.
  task automatic do_fetch(input logic adv, input int waits, input logic [31:0] rdata,
                          input logic [31:0] exp_imm, input logic [31:0] pc_before,
                          input logic poke_busy);
    int reqc;
    sb_q.push_back('{ir: rdata, imm: exp_imm, pc: adv ? pc_before + 32'd4 : pc_before});
    IR_Write = 1'b1;
    PC_Write = adv;
    @(posedge clk); #1;
    IR_Write = 1'b0;
    PC_Write = 1'b0;
    chk("busy_in_req", {31'b0, busy}, 32'd1);
    chk("imem_addr", imem_addr, pc_before);
    reqc = 0;
    for (int i = 0; i <= waits; i++) begin
      if (imem_req) reqc++;
      IR_Write = poke_busy && (i == 0);
      PC_Write = poke_busy && (i == 0);
      if (i == waits) begin
        imem_ack   = 1'b1;
        imem_rdata = rdata;
      end
      @(posedge clk); #1;
    end
    imem_ack   = 1'b0;
    IR_Write   = 1'b0;
    PC_Write   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    chk("req_cycles", reqc, waits + 1);
    chk("ir_valid_pulse", {31'b0, ir_valid}, 32'd1);
    chk("busy_after_ack", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("ir_valid_one_cycle", {31'b0, ir_valid}, 32'd0);
    chk("no_refetch", {31'b0, imem_req}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t expected=finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    IR_Write = 1'b0; PC_Write = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    IR_Write2 = 1'b0; PC_Write2 = 1'b0; imem_ack2 = 1'b0; imem_rdata2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ir_valid", {31'b0, ir_valid}, 32'd0);
    chk("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
    chk("rst_ir", {funct7, rs2, rs1, funct3, rd, opcode}, 32'h0000_0013);
    chk("rst_imm", imm, 32'h0);
    chk("rst_pc_wrap_dut", pc2, 32'hFFFF_FFFC);
    rst = 1'b0;
    @(posedge clk); #1;

    // PC wrap on the second instance
    IR_Write2 = 1'b1; PC_Write2 = 1'b1;
    @(posedge clk); #1;
    IR_Write2 = 1'b0; PC_Write2 = 1'b0;
    chk("wrap_addr", imem_addr2, 32'hFFFF_FFFC);
    imem_ack2 = 1'b1; imem_rdata2 = 32'h0050_0093;
    @(posedge clk); #1;
    imem_ack2 = 1'b0;
    chk("wrap_ir_valid", {31'b0, ir_valid2}, 32'd1);
    chk("wrap_pc", pc2, 32'h0);
    chk("wrap_imm", imm2, 32'd5);

    do_fetch(1'b1, 0, 32'h0050_0093, 32'd5,          32'd0,  1'b0);
    do_fetch(1'b1, 3, 32'h1234_50B7, 32'h1234_5000,  32'd4,  1'b0);
    do_fetch(1'b0, 2, 32'h00A0_0113, 32'd10,         32'd8,  1'b1);
    do_fetch(1'b1, 1, 32'hFFF0_0093, 32'hFFFF_FFFF,  32'd8,  1'b0);
    do_fetch(1'b1, 0, 32'h8000_00B7, 32'h8000_0000,  32'd12, 1'b0);
    do_fetch(1'b0, 2, 32'h0020_81B3, 32'd0,          32'd16, 1'b0);
    do_fetch(1'b1, 0, 32'h4020_81B3, 32'd0,          32'd16, 1'b0);

    // ack while idle is ignored
    imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    chk("idle_ack_ir_valid", {31'b0, ir_valid}, 32'd0);
    chk("idle_ack_ir", {funct7, rs2, rs1, funct3, rd, opcode}, 32'h4020_81B3);
    chk("idle_ack_pc", pc, 32'd20);

`ifdef IFETCH_WATCHDOG_EN
    begin
      int reqc;
      IR_Write = 1'b1; PC_Write = 1'b1;
      @(posedge clk); #1;
      IR_Write = 1'b0; PC_Write = 1'b0;
      reqc = 0;
      for (int i = 0; i < 40 && imem_req; i++) begin
        reqc++;
        @(posedge clk); #1;
      end
      chk("wd_req_cycles", reqc, 16);
      chk("wd_fetch_err", {31'b0, fetch_err}, 32'd1);
      chk("wd_req_dropped", {31'b0, imem_req}, 32'd0);
      chk("wd_ir_kept", {funct7, rs2, rs1, funct3, rd, opcode}, 32'h4020_81B3);
      chk("wd_pc_kept", pc, 32'd20);
    end
`else
    begin
      int reqc;
      sb_q.push_back('{ir: 32'h0000_0013, imm: 32'd0, pc: 32'd20});
      IR_Write = 1'b1; PC_Write = 1'b0;
      @(posedge clk); #1;
      IR_Write = 1'b0;
      reqc = 0;
      for (int i = 0; i < 20; i++) begin
        if (imem_req) reqc++;
        @(posedge clk); #1;
      end
      chk("nowd_req_held", reqc, 20);
      chk("nowd_fetch_err", {31'b0, fetch_err}, 32'd0);
      imem_ack = 1'b1; imem_rdata = 32'h0000_0013;
      @(posedge clk); #1;
      imem_ack = 1'b0;
      chk("nowd_ir_valid", {31'b0, ir_valid}, 32'd1);
      @(posedge clk); #1;
    end
`endif

    // reset mid-fetch, ack during and just after reset
    IR_Write = 1'b1; PC_Write = 1'b1;
    @(posedge clk); #1;
    IR_Write = 1'b0; PC_Write = 1'b0;
    chk("mid_req_before_rst", {31'b0, imem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req", {31'b0, imem_req}, 32'd0);
    chk("async_rst_pc", pc, 32'd0);
    chk("async_rst_ir", {funct7, rs2, rs1, funct3, rd, opcode}, 32'h0000_0013);
    chk("async_rst_fetch_err", {31'b0, fetch_err}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    chk("late_ack_ir", {funct7, rs2, rs1, funct3, rd, opcode}, 32'h0000_0013);
    chk("late_ack_pc", pc, 32'd0);
    chk("late_ack_ir_valid", {31'b0, ir_valid}, 32'd0);
    chk("late_ack_busy", {31'b0, busy}, 32'd0);
    chk("late_ack_req", {31'b0, imem_req}, 32'd0);

    @(posedge clk); #1;
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
